// File: rtl/um_mem_ctrl_pkg.sv
// Shared bus/op types for the UM memory request sequencer and its copy engine.
package um_mem_ctrl_pkg;

   typedef enum logic [1:0] {
      MEM_READ    = 2'b00,
      MEM_WRITE   = 2'b01,
      MEM_ALLOC   = 2'b10,
      MEM_SETZERO = 2'b11
   } mem_mode_t;

   typedef enum logic [1:0] {
      OP_INDEX    = 2'b00,
      OP_AMEND    = 2'b01,
      OP_ALLOC    = 2'b10,
      OP_LOADPROG = 2'b11
   } um_mem_op_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RESP,
      ST_CAPTURE,
      ST_CP_READ,
      ST_CP_WRITE,
      ST_SWITCH
   } ctl_state_t;

   typedef struct packed {
      mem_mode_t   mode;
      logic [31:0] address;
      logic [31:0] offset;
      logic [31:0] data;
   } mem_in_bus_t;

   // mem_sys has no nop, so an idle bus is a harmless read of word 0
   localparam mem_in_bus_t IDLE_BUS = '{mode: MEM_READ, address: 32'd0, offset: 32'd0, data: 32'd0};

   function automatic mem_in_bus_t issue_bus(input um_mem_op_t  op,
                                             input logic [31:0] arr,
                                             input logic [31:0] off,
                                             input logic [31:0] dat,
                                             input logic        copy);
      mem_in_bus_t b;
      b = IDLE_BUS;
      case (op)
         OP_INDEX: begin
            b.address = arr;
            b.offset  = off;
         end
         OP_AMEND: begin
            b.mode    = MEM_WRITE;
            b.address = arr;
            b.offset  = off;
            b.data    = dat;
         end
         OP_ALLOC: begin
            b.mode   = MEM_ALLOC;
            b.offset = off;
         end
         default: begin
            // loading array 0 onto itself changes nothing
            if (copy) begin
               b.mode   = MEM_ALLOC;
               b.offset = off;
            end else if (arr != 32'd0) begin
               b.mode = MEM_SETZERO;
               b.data = arr;
            end
         end
      endcase
      return b;
   endfunction

endpackage

// File: rtl/um_mem_ctrl_mem_copy_seq.sv
// Word-by-word copy engine for LOADPROG: owns the word counter, new base and CP_* sequencing.
module mem_copy_seq
   import um_mem_ctrl_pkg::*;
#(
   parameter int LEN_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  ctl_state_t       state,
   input  logic [31:0]      src,
   input  logic [LEN_W-1:0] len,
   input  logic [31:0]      mem_data,
   output ctl_state_t       copy_next,
   output mem_in_bus_t      copy_bus
);

   logic [LEN_W-1:0] cnt, cnt_inc;
   logic [31:0]      base_reg;

   assign cnt_inc = cnt + LEN_W'(1);

   // mem_sys answers combinationally, so leaving CAPTURE samples the ALLOC result
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt      <= '0;
         base_reg <= '0;
      end else if (start) begin
         cnt <= '0;
      end else if (state == ST_CAPTURE) begin
         base_reg <= mem_data;
      end else if (state == ST_CP_WRITE) begin
         cnt <= cnt_inc;
      end
   end

   always_comb begin
      copy_next = ST_IDLE;
      copy_bus  = IDLE_BUS;
      case (state)
         ST_CAPTURE: copy_next = (len != '0) ? ST_CP_READ : ST_SWITCH;
         ST_CP_READ: begin
            copy_next = ST_CP_WRITE;
            copy_bus  = '{mode: MEM_READ, address: src, offset: 32'(cnt), data: 32'd0};
         end
         ST_CP_WRITE: begin
            copy_next = (cnt_inc < len) ? ST_CP_READ : ST_SWITCH;
            copy_bus  = '{mode: MEM_WRITE, address: base_reg, offset: 32'(cnt), data: mem_data};
         end
         ST_SWITCH: begin
            copy_next = ST_RESP;
            copy_bus  = '{mode: MEM_SETZERO, address: 32'd0, offset: 32'd0, data: base_reg};
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/um_mem_ctrl.sv
// UM memory request sequencer in front of mem_sys; one response pulse per op.
// UMIX_MEMCTL_COPY_EN selects the copying LOADPROG instead of the plain alias switch.
module um_mem_ctrl
   import um_mem_ctrl_pkg::*;
#(
   parameter int LEN_W         = 32,
   parameter bit RESP_ON_WRITE = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  req_op,
   input  logic [31:0] req_array,
   input  logic [31:0] req_offset,
   input  logic [31:0] req_data,
   output mem_in_bus_t mem_bus,
   output logic        mem_en,
   input  logic [31:0] mem_data,
   output logic        resp_valid,
   output logic [31:0] resp_data,
   output logic        busy
);

   ctl_state_t  state, state_d, copy_next;
   um_mem_op_t  op_q, req_op_e;
   mem_in_bus_t bus_d, copy_bus;
   logic        accept, copy_sel, rd_op, resp_valid_d;
   logic [31:0] resp_data_d;

   assign req_op_e  = um_mem_op_t'(req_op);
   assign req_ready = (state == ST_IDLE);
   assign accept    = req_valid && req_ready;
   assign busy      = (state != ST_IDLE);
   assign mem_en    = ~reset;
   assign rd_op     = (op_q == OP_INDEX) || (op_q == OP_ALLOC);

`ifdef UMIX_MEMCTL_COPY_EN
   logic [31:0] arr_q, off_q;

   assign copy_sel = (req_op_e == OP_LOADPROG) && (req_array != 32'd0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         arr_q <= '0;
         off_q <= '0;
      end else if (accept) begin
         arr_q <= req_array;
         off_q <= req_offset;
      end
   end

   mem_copy_seq #(.LEN_W(LEN_W)) u_copy (
      .clk       (clk),
      .reset     (reset),
      .start     (accept && copy_sel),
      .state     (state),
      .src       (arr_q),
      .len       (off_q[LEN_W-1:0]),
      .mem_data  (mem_data),
      .copy_next (copy_next),
      .copy_bus  (copy_bus)
   );
`else
   assign copy_sel  = 1'b0;
   assign copy_next = ST_IDLE;
   assign copy_bus  = IDLE_BUS;
`endif

   // state holds the phase the next edge will put on the registered outputs
   always_comb begin
      state_d      = state;
      bus_d        = mem_bus;
      resp_valid_d = 1'b0;
      resp_data_d  = resp_data;
      case (state)
         ST_IDLE: begin
            bus_d = IDLE_BUS;
            if (accept) begin
               bus_d   = issue_bus(req_op_e, req_array, req_offset, req_data, copy_sel);
               state_d = copy_sel ? ST_CAPTURE : ST_RESP;
            end
         end
         ST_RESP: begin
            bus_d        = IDLE_BUS;
            state_d      = ST_IDLE;
            resp_valid_d = RESP_ON_WRITE || rd_op;
            resp_data_d  = rd_op ? mem_data : 32'd0;
         end
         default: begin
            bus_d   = copy_bus;
            state_d = copy_next;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= ST_IDLE;
         mem_bus    <= IDLE_BUS;
         resp_valid <= 1'b0;
         resp_data  <= '0;
         op_q       <= OP_INDEX;
      end else begin
         state      <= state_d;
         mem_bus    <= bus_d;
         resp_valid <= resp_valid_d;
         resp_data  <= resp_data_d;
         if (accept) op_q <= req_op_e;
      end
   end

endmodule

// File: tb/tb_um_mem_ctrl.sv
// Scoreboard bench for um_mem_ctrl with a small combinational mem_sys model.
module tb_um_mem_ctrl;
   import um_mem_ctrl_pkg::*;

   logic        clk = 1'b0, reset = 1'b1, req_valid = 1'b0;
   logic        req_ready, mem_en, resp_valid, busy;
   logic [1:0]  req_op = 2'b00;
   logic [31:0] req_array = '0, req_offset = '0, req_data = '0;
   logic [31:0] mem_data, resp_data;
   mem_in_bus_t mem_bus;

   um_mem_ctrl dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_array(req_array), .req_offset(req_offset), .req_data(req_data),
      .mem_bus(mem_bus), .mem_en(mem_en), .mem_data(mem_data),
      .resp_valid(resp_valid), .resp_data(resp_data), .busy(busy)
   );

   always #5 clk = ~clk;

   // mem_sys model: flat word memory, array 0 aliases prog_base, bump allocator
   logic [31:0] mem [256];
   logic [31:0] next_free = 32'h10;
   logic [31:0] prog_base = 32'h80;
   logic [31:0] ea;

   initial for (int i = 0; i < 256; i++) mem[i] = 32'd0;

   always_comb begin
      ea       = ((mem_bus.address == 32'd0) ? prog_base : mem_bus.address) + mem_bus.offset;
      mem_data = 32'd0;
      case (mem_bus.mode)
         MEM_READ:  mem_data = mem[ea[7:0]];
         MEM_ALLOC: mem_data = next_free;
         default: ;
      endcase
   end

   always @(posedge clk) begin
      if (mem_en) begin
         case (mem_bus.mode)
            MEM_WRITE:   mem[ea[7:0]] <= mem_bus.data;
            MEM_ALLOC:   next_free <= next_free + mem_bus.offset;
            MEM_SETZERO: prog_base <= mem_bus.data;
            default: ;
         endcase
      end
   end

   int n_chk = 0, n_err = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", tag, act, exp);
      end
   endtask

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   mem_in_bus_t bus_log   [4096];
   logic        resp_log  [4096];
   logic        ready_log [4096];
   logic [31:0] exp_q [$];

   always @(negedge clk) begin
      bus_log[cyc & 4095]   = mem_bus;
      resp_log[cyc & 4095]  = resp_valid;
      ready_log[cyc & 4095] = req_ready;
      if (!reset && resp_valid) begin
         if (exp_q.size() == 0) chk("resp_extra", 32'(exp_q.size()), 32'd1);
         else                   chk("resp_data", resp_data, exp_q.pop_front());
      end
   end

   function automatic int cnt_mode(input int from, input int to, input mem_mode_t m);
      int n = 0;
      for (int c = from; c <= to; c++) if (bus_log[c & 4095].mode == m) n++;
      return n;
   endfunction

   function automatic int cnt_resp(input int from, input int to);
      int n = 0;
      for (int c = from; c <= to; c++) if (resp_log[c & 4095]) n++;
      return n;
   endfunction

   // called at a negedge; returns at the negedge of cycle acc (acc = accept edge)
   task automatic issue(input logic [1:0] op, input logic [31:0] arr, input logic [31:0] off,
                        input logic [31:0] dat, input logic [31:0] exp, input bit push,
                        input bit keep, output int acc);
      int w = 0;
      req_valid  = 1'b1;
      req_op     = op;
      req_array  = arr;
      req_offset = off;
      req_data   = dat;
      while (!req_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      if (!req_ready) chk("ready_timeout", 32'(req_ready), 32'd1);
      acc = cyc + 1;
      if (push) exp_q.push_back(exp);
      @(posedge clk);
      @(negedge clk);
      if (!keep) req_valid = 1'b0;
   endtask

   task automatic drain();
      int w = 0;
      while (!(exp_q.size() == 0 && req_ready) && w < 60) begin
         @(negedge clk);
         w++;
      end
      if (exp_q.size() != 0) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      int a, a0, a1, a2;
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int a, a0, a1, a2;
      repeat (3) @(negedge clk);
      chk("rst_ready", 32'(req_ready), 32'd1);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_resp_data", resp_data, 32'd0);
      chk("rst_mem_en", 32'(mem_en), 32'd0);
      chk("rst_bus_mode", 32'(mem_bus.mode), 32'd0);
      chk("rst_bus_addr", mem_bus.address | mem_bus.offset | mem_bus.data, 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      reset = 1'b0;
      #1 chk("run_mem_en", 32'(mem_en), 32'd1);
      @(negedge clk);

      issue(2'b10, 32'h0, 32'd4, 32'h0, 32'h10, 1, 0, a);
      drain();
      chk("alloc_bus_mode", 32'(bus_log[a & 4095].mode), 32'(MEM_ALLOC));
      chk("alloc_bus_off", bus_log[a & 4095].offset, 32'd4);
      chk("alloc_resp_cyc", 32'(resp_log[(a + 1) & 4095]), 32'd1);

      issue(2'b01, 32'h10, 32'd2, 32'hDEADBEEF, 32'h0, 1, 0, a);
      drain();
      chk("amend_bus_mode", 32'(bus_log[a & 4095].mode), 32'(MEM_WRITE));
      chk("amend_bus_data", bus_log[a & 4095].data, 32'hDEADBEEF);
      issue(2'b00, 32'h10, 32'd2, 32'h0, 32'hDEADBEEF, 1, 0, a);
      drain();

      for (int i = 0; i < 3; i++) begin
         issue(2'b01, 32'h10, 32'(i), 32'(i + 1), 32'h0, 1, 0, a);
         drain();
      end

      issue(2'b00, 32'h10, 32'd0, 32'h0, 32'd1, 1, 1, a0);
      issue(2'b00, 32'h10, 32'd1, 32'h0, 32'd2, 1, 1, a1);
      issue(2'b00, 32'h10, 32'd2, 32'h0, 32'd3, 1, 0, a2);
      drain();
      chk("b2b_gap1", 32'(a1 - a0), 32'd2);
      chk("b2b_gap2", 32'(a2 - a1), 32'd2);
      chk("b2b_ready_lo", 32'(ready_log[a0 & 4095]), 32'd0);
      chk("b2b_ready_hi", 32'(ready_log[(a0 + 1) & 4095]), 32'd1);
      chk("b2b_resp_cnt", 32'(cnt_resp(a0 + 1, a2 + 1)), 32'd3);

`ifdef UMIX_MEMCTL_COPY_EN
      issue(2'b11, 32'h10, 32'd3, 32'h0, 32'h0, 1, 0, a);
      drain();
      chk("cp_read0_addr", bus_log[(a + 2) & 4095].address, 32'h10);
      for (int i = 0; i < 3; i++) begin
         chk("cp_wr_mode", 32'(bus_log[(a + 3 + 2 * i) & 4095].mode), 32'(MEM_WRITE));
         chk("cp_wr_addr", bus_log[(a + 3 + 2 * i) & 4095].address, 32'h14);
         chk("cp_wr_off", bus_log[(a + 3 + 2 * i) & 4095].offset, 32'(i));
         chk("cp_wr_data", bus_log[(a + 3 + 2 * i) & 4095].data, 32'(i + 1));
      end
      chk("cp_sw_mode", 32'(bus_log[(a + 8) & 4095].mode), 32'(MEM_SETZERO));
      chk("cp_sw_data", bus_log[(a + 8) & 4095].data, 32'h14);
      chk("cp_resp_cyc", 32'(resp_log[(a + 9) & 4095]), 32'd1);
      chk("cp_wr_count", 32'(cnt_mode(a, a + 9, MEM_WRITE)), 32'd3);
      issue(2'b00, 32'h0, 32'd1, 32'h0, 32'd2, 1, 0, a);
      drain();

      issue(2'b11, 32'h0, 32'd5, 32'h0, 32'h0, 1, 0, a);
      drain();
      chk("lp0_no_write", 32'(cnt_mode(a, a + 6, MEM_WRITE)), 32'd0);
      chk("lp0_no_switch", 32'(cnt_mode(a, a + 6, MEM_SETZERO)), 32'd0);
      chk("lp0_resp_cyc", 32'(resp_log[(a + 1) & 4095]), 32'd1);

      issue(2'b11, 32'h10, 32'd0, 32'h0, 32'h0, 1, 0, a);
      drain();
      chk("n0_no_write", 32'(cnt_mode(a, a + 4, MEM_WRITE)), 32'd0);
      chk("n0_sw_mode", 32'(bus_log[(a + 2) & 4095].mode), 32'(MEM_SETZERO));
      chk("n0_sw_data", bus_log[(a + 2) & 4095].data, 32'h17);
      chk("n0_resp_cyc", 32'(resp_log[(a + 3) & 4095]), 32'd1);

      issue(2'b11, 32'h10, 32'd3, 32'h0, 32'h0, 0, 0, a);
      repeat (3) @(negedge clk);
`else
      issue(2'b11, 32'h10, 32'd7, 32'h0, 32'h0, 1, 0, a);
      drain();
      chk("alias_mode", 32'(bus_log[a & 4095].mode), 32'(MEM_SETZERO));
      chk("alias_data", bus_log[a & 4095].data, 32'h10);
      chk("alias_resp_cyc", 32'(resp_log[(a + 1) & 4095]), 32'd1);
      issue(2'b00, 32'h0, 32'd2, 32'h0, 32'd3, 1, 0, a);
      drain();

      issue(2'b00, 32'h10, 32'd0, 32'h0, 32'h0, 0, 0, a);
`endif
      reset = 1'b1;
      @(negedge clk);
      chk("mid_rst_ready", 32'(req_ready), 32'd1);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("mid_rst_bus_mode", 32'(mem_bus.mode), 32'd0);
      chk("mid_rst_bus_rest", mem_bus.address | mem_bus.offset | mem_bus.data, 32'd0);
      reset = 1'b0;
      repeat (12) @(negedge clk);
      chk("mid_rst_no_resp", 32'(cnt_resp(a, a + 14)), 32'd0);

      issue(2'b00, 32'h10, 32'd1, 32'h0, 32'd2, 1, 0, a);
      drain();
      chk("final_drain", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
